// File: rtl/key_debounce_if.sv
// rtl/key_debounce_if.sv - key bundle between the push-button pins and the debouncer
// Signals:
//   btn_in    raw asynchronous key inputs, 1 = pressed
//   btn_out   one-cycle press pulse per key
//   btn_level debounced level per key, 1 while the key is considered pressed
// Modports:
//   master    the board/pin side that drives btn_in and consumes the results
//   slave     the debouncer
interface key_debounce_if #(
  parameter int NUM_KEYS = 8
);
  logic [NUM_KEYS-1:0] btn_in;
  logic [NUM_KEYS-1:0] btn_out;
  logic [NUM_KEYS-1:0] btn_level;

  modport master (output btn_in, input btn_out, input btn_level);
  modport slave  (input btn_in, output btn_out, output btn_level);
endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronise, debounce and edge-detect NUM_KEYS push-buttons
// Purpose: each key passes a 2-flop synchroniser and an independent debounce FSM
//   (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT). A key must read the same value for
//   DEBOUNCE_TICKS consecutive samples to change its debounced level; a clean press
//   produces one registered btn_out pulse.
// Ports:
//   clk_1kHz  in   sole clock, all state on its rising edge
//   rst_n     in   asynchronous active-low reset
//   keys      key_debounce_if.slave: btn_in (raw), btn_out (pulse), btn_level (level)
// Build option: define KEY_AUTOREPEAT_EN to emit extra pulses while a key is held
//   (first after REPEAT_DELAY ticks in PRESSED, then every REPEAT_PERIOD ticks).
module key_debounce #(
  parameter int NUM_KEYS       = 8,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_PERIOD  = 250
) (
  input  logic          clk_1kHz,
  input  logic          rst_n,
  key_debounce_if.slave keys
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_TICKS - 1);

  if (DEBOUNCE_TICKS < 2 || DEBOUNCE_TICKS > 255 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
    begin : g_bad_cfg
      $error("key_debounce: illegal parameter value");
    end

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [NUM_KEYS-1:0] sync1_q, sync1_d;
  logic [NUM_KEYS-1:0] sync2_q, sync2_d;
  logic [NUM_KEYS-1:0] btn_out_w;
  logic [NUM_KEYS-1:0] btn_level_w;

  always_comb begin
    sync1_d = keys.btn_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk_1kHz or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       out_q, out_d;
    logic       level_q, level_d;
    logic       s;

    assign s = sync2_q[k];

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [9:0] REP_FIRST = 10'(REPEAT_DELAY);
    localparam logic [9:0] REP_NEXT  = 10'(REPEAT_PERIOD);
    logic [9:0] rep_q, rep_d, rep_inc;
    // rpt_q marks that the first repeat has fired, so later ones use REP_NEXT
    logic       rpt_q, rpt_d;
`endif

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = 1'b0;
      case (state_q)
        IDLE: begin
          if (s) begin
            state_d = PRESS_WAIT;
            cnt_d   = 8'd1;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = PRESSED;
            cnt_d   = 8'd0;
            out_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        PRESSED: begin
          if (!s) begin
            state_d = RELEASE_WAIT;
            cnt_d   = 8'd1;
          end
        end
        RELEASE_WAIT: begin
          // Returning to PRESSED is a bounce on release: no new pulse
          if (s) begin
            state_d = PRESSED;
            cnt_d   = 8'd0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end
      endcase

`ifdef KEY_AUTOREPEAT_EN
      rep_d   = rep_q;
      rpt_d   = rpt_q;
      rep_inc = rep_q + 10'd1;
      // Only ticks that stay in PRESSED advance the counter; any other path
      // (entry, release bounce) restarts it from zero.
      if (state_q == PRESSED && s) begin
        if (rep_inc == (rpt_q ? REP_NEXT : REP_FIRST)) begin
          out_d = 1'b1;
          rep_d = 10'd0;
          rpt_d = 1'b1;
        end else begin
          rep_d = rep_inc;
        end
      end else begin
        rep_d = 10'd0;
        rpt_d = 1'b0;
      end
`endif

      level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    always_ff @(posedge clk_1kHz or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        cnt_q   <= 8'd0;
        out_q   <= 1'b0;
        level_q <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        rep_q   <= 10'd0;
        rpt_q   <= 1'b0;
`endif
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        out_q   <= out_d;
        level_q <= level_d;
`ifdef KEY_AUTOREPEAT_EN
        rep_q   <= rep_d;
        rpt_q   <= rpt_d;
`endif
      end
    end

    assign btn_out_w[k]   = out_q;
    assign btn_level_w[k] = level_q;
  end

  assign keys.btn_out   = btn_out_w;
  assign keys.btn_level = btn_level_w;

endmodule
